// File: rtl/clock_mode_controller.sv
// Mode/set sequencer for the digital clock: key sync, mode FSM, blink masks and adjust pulses.
// Define AUTO_REPEAT_EN to enable auto-repeat of KeyAdj while held in a SET state.
module clock_mode_controller #(
  parameter int unsigned TIMEOUT_S   = 10,
  parameter int unsigned REPEAT_DLY  = 12000000,
  parameter int unsigned REPEAT_RATE = 3000000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       Tick1Hz,
  input  logic       KeyMode,
  input  logic       KeyAdj,
  output logic       SwitchMHToS,
  output logic       DisplayA,
  output logic       AdjHour,
  output logic       AdjMinutes,
  output logic       AdjAHour,
  output logic       AdjAMinutes,
  output logic       BlankHi,
  output logic       BlankLo,
  output logic [2:0] Mode
);

  if (TIMEOUT_S < 1 || TIMEOUT_S > 255 || REPEAT_DLY < 1 || REPEAT_RATE < 1 ||
      REPEAT_DLY > 24'hFFFFFF || REPEAT_RATE > 24'hFFFFFF) begin : gen_bad_param
    $error("clock_mode_controller: parameter out of range");
  end

  typedef enum logic [2:0] {
    StRunHm, StRunMs, StAlarmView, StSetHour, StSetMin, StSetAhour, StSetAmin, StBad
  } state_e;

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_S);

  state_e     state_q, state_d;
  logic [1:0] mode_sync_q, adj_sync_q;
  logic       mode_dly_q, adj_dly_q;
  logic [7:0] tcnt_q, tcnt_d;
  logic       blink_q, blink_d;
  logic       mode_edge, adj_edge, in_set, press, rpt_due, fire;
  logic       sw_d, disp_a_d, blank_hi_d, blank_lo_d;
  logic [3:0] adj_d;

  assign mode_edge = mode_sync_q[1] & ~mode_dly_q;
  assign adj_edge  = adj_sync_q[1] & ~adj_dly_q;
  assign in_set    = state_q inside {StSetHour, StSetMin, StSetAhour, StSetAmin};
  // A mode edge always wins over any adjust pulse in the same cycle.
  assign press     = adj_edge & ~mode_edge & in_set;
  assign fire      = press | (rpt_due & ~mode_edge & in_set);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    if (mode_edge) begin
      case (state_q)
        StRunHm:     state_d = StRunMs;
        StRunMs:     state_d = StAlarmView;
        StAlarmView: state_d = StSetHour;
        StSetHour:   state_d = StSetMin;
        StSetMin:    state_d = StSetAhour;
        StSetAhour:  state_d = StSetAmin;
        default:     state_d = StRunHm;
      endcase
    end else if (state_q == StBad) begin
      state_d = StRunHm;
    end else if (!fire && Tick1Hz && state_q != StRunHm) begin
      if (tcnt_q + 8'd1 == TimeoutLim) begin
        state_d = StRunHm;
      end else begin
        tcnt_d = tcnt_q + 8'd1;
      end
    end
    if (fire || state_d != state_q) begin
      tcnt_d = '0;
    end
  end

  always_comb begin
    blink_d = blink_q;
    if (fire || (state_d != state_q &&
                 state_d inside {StSetHour, StSetMin, StSetAhour, StSetAmin})) begin
      blink_d = 1'b0;
    end else if (Tick1Hz) begin
      blink_d = ~blink_q;
    end
    sw_d       = (state_d == StRunMs);
    disp_a_d   = state_d inside {StAlarmView, StSetAhour, StSetAmin};
    blank_hi_d = blink_d & (state_d inside {StSetHour, StSetAhour});
    blank_lo_d = blink_d & (state_d inside {StSetMin, StSetAmin});
    adj_d      = '0;
    if (fire) begin
      case (state_q)
        StSetHour:  adj_d = 4'b1000;
        StSetMin:   adj_d = 4'b0100;
        StSetAhour: adj_d = 4'b0010;
        StSetAmin:  adj_d = 4'b0001;
        default:    adj_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q     <= StRunHm;
      mode_sync_q <= '0;
      adj_sync_q  <= '0;
      mode_dly_q  <= 1'b0;
      adj_dly_q   <= 1'b0;
      tcnt_q      <= '0;
      blink_q     <= 1'b0;
      SwitchMHToS <= 1'b0;
      DisplayA    <= 1'b0;
      BlankHi     <= 1'b0;
      BlankLo     <= 1'b0;
      {AdjHour, AdjMinutes, AdjAHour, AdjAMinutes} <= '0;
    end else begin
      state_q     <= state_d;
      mode_sync_q <= {mode_sync_q[0], KeyMode};
      adj_sync_q  <= {adj_sync_q[0], KeyAdj};
      mode_dly_q  <= mode_sync_q[1];
      adj_dly_q   <= adj_sync_q[1];
      tcnt_q      <= tcnt_d;
      blink_q     <= blink_d;
      SwitchMHToS <= sw_d;
      DisplayA    <= disp_a_d;
      BlankHi     <= blank_hi_d;
      BlankLo     <= blank_lo_d;
      {AdjHour, AdjMinutes, AdjAHour, AdjAMinutes} <= adj_d;
    end
  end

  assign Mode = state_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [23:0] DlyLim  = 24'(REPEAT_DLY);
  localparam logic [23:0] RateLim = 24'(REPEAT_RATE);

  logic [23:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_on_q, rpt_on_d, rpt_first_q, rpt_first_d;

  // rpt_cnt_q holds cycles elapsed since the last pulse (press or repeat).
  assign rpt_due = rpt_on_q & adj_sync_q[1] &
                   (rpt_cnt_q == (rpt_first_q ? DlyLim : RateLim));

  always_comb begin
    rpt_on_d    = rpt_on_q;
    rpt_first_d = rpt_first_q;
    rpt_cnt_d   = rpt_cnt_q;
    if (press) begin
      rpt_on_d    = 1'b1;
      rpt_first_d = 1'b1;
      rpt_cnt_d   = 24'd1;
    end else if (!rpt_on_q || !adj_sync_q[1] || mode_edge || state_d != state_q) begin
      rpt_on_d    = 1'b0;
      rpt_first_d = 1'b0;
      rpt_cnt_d   = '0;
    end else if (fire) begin
      rpt_first_d = 1'b0;
      rpt_cnt_d   = 24'd1;
    end else begin
      rpt_cnt_d   = rpt_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      rpt_on_q    <= 1'b0;
      rpt_first_q <= 1'b0;
      rpt_cnt_q   <= '0;
    end else begin
      rpt_on_q    <= rpt_on_d;
      rpt_first_q <= rpt_first_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end
`else
  assign rpt_due = 1'b0;
`endif

endmodule

// File: tb/tb_clock_mode_controller.sv
// Bench for clock_mode_controller: directed scenarios plus random keys/ticks against a
// behavioural model of modes, seconds-timeout, blink phase and adjust pulses.
module tb_clock_mode_controller;

  localparam int unsigned TimeoutS   = 3;
  localparam int unsigned RepeatDly  = 8;
  localparam int unsigned RepeatRate = 4;

  logic       CP = 1'b0;
  logic       CR, Tick1Hz, KeyMode, KeyAdj;
  logic       SwitchMHToS, DisplayA, AdjHour, AdjMinutes, AdjAHour, AdjAMinutes;
  logic       BlankHi, BlankLo;
  logic [2:0] Mode;
  logic [10:0] dut_vec;

  clock_mode_controller #(
    .TIMEOUT_S  (TimeoutS),
    .REPEAT_DLY (RepeatDly),
    .REPEAT_RATE(RepeatRate)
  ) dut (
    .CP         (CP),
    .CR         (CR),
    .Tick1Hz    (Tick1Hz),
    .KeyMode    (KeyMode),
    .KeyAdj     (KeyAdj),
    .SwitchMHToS(SwitchMHToS),
    .DisplayA   (DisplayA),
    .AdjHour    (AdjHour),
    .AdjMinutes (AdjMinutes),
    .AdjAHour   (AdjAHour),
    .AdjAMinutes(AdjAMinutes),
    .BlankHi    (BlankHi),
    .BlankLo    (BlankLo),
    .Mode       (Mode)
  );

  always #5 CP = ~CP;

  assign dut_vec = {Mode, SwitchMHToS, DisplayA, AdjHour, AdjMinutes, AdjAHour, AdjAMinutes,
                    BlankHi, BlankLo};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int cnt_hour, cnt_other, cnt_adj;
  bit lo_seen;
  int min_q[$];

  // Reference model state: key histories (index 0 = value sampled at this edge).
  int       m_mode, m_tcnt;
  bit       m_blink;
  bit [3:0] km_h, ka_h, m_adj;
`ifdef AUTO_REPEAT_EN
  bit       m_rpt_on, m_first;
  int       m_since;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
  endtask

  function automatic bit is_set(input int m);
    return m >= 3 && m <= 6;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_tcnt = 0; m_blink = 0; km_h = '0; ka_h = '0; m_adj = '0;
`ifdef AUTO_REPEAT_EN
    m_rpt_on = 0; m_first = 0; m_since = 0;
`endif
  endtask

  task automatic model_edge(input bit km, input bit ka, input bit tick);
    bit me, ae, held, pulse, due;
    int old;
    km_h  = {km_h[2:0], km};
    ka_h  = {ka_h[2:0], ka};
    me    = km_h[2] & ~km_h[3];
    ae    = ka_h[2] & ~ka_h[3];
    held  = ka_h[2];
    old   = m_mode;
    pulse = 0;
    due   = 0;
`ifdef AUTO_REPEAT_EN
    if (m_rpt_on && held) begin
      m_since++;
      due = (m_since == int'(m_first ? RepeatDly : RepeatRate));
    end
`endif
    if (me) m_mode = (old + 1) % 7;
    else if (is_set(old) && (ae || due)) pulse = 1;
    else if (tick && old != 0 && m_tcnt + 1 == int'(TimeoutS)) m_mode = 0;
    if (me || pulse || m_mode != old) m_tcnt = 0;
    else if (tick && old != 0) m_tcnt++;
    if (pulse || (is_set(m_mode) && m_mode != old)) m_blink = 0;
    else if (tick) m_blink = ~m_blink;
    m_adj = pulse ? (4'b1000 >> (old - 3)) : 4'b0000;
`ifdef AUTO_REPEAT_EN
    if (pulse && ae) begin
      m_rpt_on = 1; m_first = 1; m_since = 0;
    end else if (pulse) begin
      m_first = 0; m_since = 0;
    end else if (!held || me || m_mode != old) begin
      m_rpt_on = 0; m_since = 0;
    end
`endif
  endtask

  function automatic logic [10:0] model_vec();
    logic [2:0] md;
    md = 3'(m_mode);
    return {md, m_mode == 1, m_mode == 2 || m_mode == 5 || m_mode == 6, m_adj,
            m_blink && (m_mode == 3 || m_mode == 5), m_blink && (m_mode == 4 || m_mode == 6)};
  endfunction

  task automatic step(input bit km, input bit ka, input bit tick);
    @(negedge CP);
    KeyMode = km;
    KeyAdj  = ka;
    Tick1Hz = tick;
    @(posedge CP);
    model_edge(km, ka, tick);
    #1;
    cyc++;
    check_eq("cycle", 32'(dut_vec), 32'(model_vec()));
    if (AdjHour) cnt_hour++;
    if (AdjMinutes | AdjAHour | AdjAMinutes) cnt_other++;
    if (AdjHour | AdjMinutes | AdjAHour | AdjAMinutes) cnt_adj++;
    if (AdjMinutes) min_q.push_back(cyc);
    if (BlankLo) lo_seen = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic press_mode();
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    idle(3);
  endtask

  task automatic press_adj();
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge CP);
    CR = 1;
    #1;
    check_eq("reset_async", 32'(dut_vec), 32'd0);
    KeyMode = 0;
    KeyAdj  = 0;
    Tick1Hz = 0;
    model_reset();
    repeat (2) @(negedge CP);
    CR = 0;
  endtask

  initial begin
    bit rk_m, rk_a;
    int m;
    CR = 1; KeyMode = 0; KeyAdj = 0; Tick1Hz = 0;
    model_reset();
    repeat (2) @(negedge CP);
    check_eq("reset_state", 32'(dut_vec), 32'd0);
    CR = 0;

    // Mode walk and key-to-state latency.
    step(1, 0, 0);
    check_eq("latency_e1", 32'(Mode), 32'd0);
    step(1, 0, 0);
    check_eq("latency_e2", 32'(Mode), 32'd0);
    step(1, 0, 0);
    check_eq("latency_e3", 32'(Mode), 32'd1);
    idle(3);
    for (int i = 1; i <= 7; i++) begin
      if (i > 1) press_mode();
      m = i % 7;
      check_eq("mode_walk", 32'({Mode, SwitchMHToS, DisplayA}),
               32'({3'(m), m == 1, m == 2 || m == 5 || m == 6}));
    end

    // KeyAdj held at SET_HOUR.
    press_mode(); press_mode(); press_mode();
    cnt_hour = 0; cnt_other = 0;
    for (int i = 0; i < 100; i++) step(0, 1, 0);
    idle(3);
`ifdef AUTO_REPEAT_EN
    check_eq("hold_hour_count", 32'(cnt_hour), 32'd24);
`else
    check_eq("hold_hour_count", 32'(cnt_hour), 32'd1);
`endif
    check_eq("hold_other_count", 32'(cnt_other), 32'd0);

    // KeyAdj held 30 cycles at SET_MIN.
    press_mode();
    min_q.delete();
    for (int i = 0; i < 30; i++) step(0, 1, 0);
    idle(8);
`ifdef AUTO_REPEAT_EN
    check_eq("repeat_count", 32'(min_q.size()), 32'd7);
    check_eq("repeat_last_ofs", 32'(min_q[$] - min_q[0]), 32'd28);
`else
    check_eq("repeat_count", 32'(min_q.size()), 32'd1);
`endif

    // Timeout from SET_AHOUR, then with an adjust between ticks.
    press_mode();
    step(0, 0, 1); idle(9);
    step(0, 0, 1);
    check_eq("timeout_t2", 32'(Mode), 32'd5);
    idle(9);
    step(0, 0, 1);
    check_eq("timeout_t3", 32'(Mode), 32'd0);
    idle(9);
    for (int i = 0; i < 5; i++) press_mode();
    step(0, 0, 1); idle(9);
    step(0, 0, 1); idle(9);
    press_adj();
    step(0, 0, 1);
    check_eq("timeout_kept_t3", 32'(Mode), 32'd5);
    idle(9);
    step(0, 0, 1);
    check_eq("timeout_kept_t4", 32'(Mode), 32'd5);
    idle(9);
    step(0, 0, 1);
    check_eq("timeout_after_t5", 32'(Mode), 32'd0);
    idle(9);

    // Blink in SET_HOUR.
    press_mode(); press_mode(); press_mode();
    lo_seen = 0;
    step(0, 0, 1);
    check_eq("blink_t1", 32'(BlankHi), 32'd1);
    idle(9);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 1);
    check_eq("blink_adj_tick", 32'({AdjHour, BlankHi}), 32'b10);
    idle(3);
    step(0, 0, 1);
    check_eq("blink_t2", 32'(BlankHi), 32'd1);
    idle(9);
    step(0, 0, 1);
    check_eq("blink_t3", 32'({Mode, BlankHi}), 32'({3'd3, 1'b0}));
    check_eq("blank_lo_quiet", 32'(lo_seen), 32'd0);
    idle(3);

    // Simultaneous keys, then reset during a held adjust.
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    check_eq("mode_beats_adj", 32'({Mode, AdjHour, AdjMinutes, AdjAHour, AdjAMinutes}),
             32'({3'd4, 4'b0000}));
    idle(3);
    for (int i = 0; i < 15; i++) step(0, 1, 0);
    do_reset();
    cnt_adj = 0;
    idle(20);
    check_eq("post_reset_pulses", 32'(cnt_adj), 32'd0);
    check_eq("post_reset_mode", 32'(Mode), 32'd0);

    // Random keys and ticks against the model.
    rk_m = 0; rk_a = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 11) == 0) rk_m = ~rk_m;
      if ($urandom_range(0, 17) == 0) rk_a = ~rk_a;
      if ($urandom_range(0, 799) == 0) do_reset();
      step(rk_m, rk_a, $urandom_range(0, 6) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
